// File: rtl/vscale_hasti_arbiter.sv
// N-master to one-slave HASTI arbiter with a per-master address-capture stage.
// Define VSCALE_HASTI_ARB_RR_EN for round-robin, otherwise the lowest index wins.
module vscale_hasti_arbiter #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic                              hclk,
   input  logic                              hresetn,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
   input  logic [NUM_MASTERS-1:0]            m_hwrite,
   input  logic [NUM_MASTERS*3-1:0]          m_hsize,
   input  logic [NUM_MASTERS*3-1:0]          m_hburst,
   input  logic [NUM_MASTERS*4-1:0]          m_hprot,
   input  logic [NUM_MASTERS-1:0]            m_hmastlock,
   input  logic [NUM_MASTERS*2-1:0]          m_htrans,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hrdata,
   output logic [NUM_MASTERS-1:0]            m_hready,
   output logic [NUM_MASTERS-1:0]            m_hresp,
   output logic [ADDR_WIDTH-1:0]             s_haddr,
   output logic                              s_hwrite,
   output logic [2:0]                        s_hsize,
   output logic [2:0]                        s_hburst,
   output logic [3:0]                        s_hprot,
   output logic                              s_hmastlock,
   output logic [1:0]                        s_htrans,
   output logic [DATA_WIDTH-1:0]             s_hwdata,
   input  logic [DATA_WIDTH-1:0]             s_hrdata,
   input  logic                              s_hready,
   input  logic                              s_hresp
);

   localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;

   logic [NUM_MASTERS-1:0] pend_valid_q, pend_write_q, pend_lock_q;
   logic [ADDR_WIDTH-1:0]  pend_addr_q [NUM_MASTERS];
   logic [2:0]             pend_size_q [NUM_MASTERS];
   logic [3:0]             pend_prot_q [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] owner_q, owner_d;
   logic [NUM_MASTERS-1:0] live_req, cand, grant;
   logic                   grant_valid;
   logic [IdxW-1:0]        grant_idx;

`ifdef VSCALE_HASTI_ARB_RR_EN
   logic [IdxW-1:0] rr_ptr_q;
   int unsigned     rr_idx;
`endif

   // Burst type and the SEQ/NONSEQ distinction are irrelevant: every issue is a split single.
   logic unused_inputs;
   assign unused_inputs = ^{m_hburst, m_htrans};

   assign m_hrdata = {NUM_MASTERS{s_hrdata}};

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_hready[i] = owner_q[i] ? s_hready : ~pend_valid_q[i];
         m_hresp[i]  = owner_q[i] & s_hresp;
         live_req[i] = hresetn & m_hready[i] & m_htrans[2*i+1];
      end
   end

   always_comb begin
      cand        = pend_valid_q | live_req;
      grant_valid = 1'b0;
      grant_idx   = '0;
`ifdef VSCALE_HASTI_ARB_RR_EN
      rr_idx = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         rr_idx = 32'(rr_ptr_q) + 32'(k);
         if (rr_idx >= NUM_MASTERS) rr_idx = rr_idx - NUM_MASTERS;
         if (!grant_valid && cand[rr_idx[IdxW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = rr_idx[IdxW-1:0];
         end
      end
`else
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (cand[k]) begin
            grant_valid = 1'b1;
            grant_idx   = IdxW'(k);
         end
      end
`endif
      if (!s_hready) grant_valid = 1'b0;
      grant = '0;
      if (grant_valid) grant[grant_idx] = 1'b1;
   end

   always_comb begin
      s_htrans    = HtransIdle;
      s_haddr     = '0;
      s_hwrite    = 1'b0;
      s_hsize     = 3'b000;
      s_hburst    = 3'b000;
      s_hprot     = 4'b0000;
      s_hmastlock = 1'b0;
      s_hwdata    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) begin
            s_htrans = HtransNonseq;
            if (pend_valid_q[i]) begin
               s_haddr     = pend_addr_q[i];
               s_hwrite    = pend_write_q[i];
               s_hsize     = pend_size_q[i];
               s_hprot     = pend_prot_q[i];
               s_hmastlock = pend_lock_q[i];
            end else begin
               s_haddr     = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
               s_hwrite    = m_hwrite[i];
               s_hsize     = m_hsize[i*3 +: 3];
               s_hprot     = m_hprot[i*4 +: 4];
               s_hmastlock = m_hmastlock[i];
            end
         end
         if (owner_q[i]) s_hwdata = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Data-phase ownership only moves when the slave completes the current data phase.
   assign owner_d = s_hready ? grant : owner_q;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         owner_q      <= '0;
         pend_valid_q <= '0;
         pend_write_q <= '0;
         pend_lock_q  <= '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            pend_addr_q[i] <= '0;
            pend_size_q[i] <= 3'b000;
            pend_prot_q[i] <= 4'b0000;
         end
      end else begin
         owner_q <= owner_d;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
               pend_valid_q[i] <= 1'b0;
            end else if (live_req[i]) begin
               pend_valid_q[i] <= 1'b1;
               pend_addr_q[i]  <= m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
               pend_write_q[i] <= m_hwrite[i];
               pend_size_q[i]  <= m_hsize[i*3 +: 3];
               pend_prot_q[i]  <= m_hprot[i*4 +: 4];
               pend_lock_q[i]  <= m_hmastlock[i];
            end
         end
      end
   end

`ifdef VSCALE_HASTI_ARB_RR_EN
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rr_ptr_q <= '0;
      end else if (grant_valid) begin
         rr_ptr_q <= (grant_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: two AHB master models, a slave model with wait/error
// injection, and a scoreboard of expected slave transfers checked by a monitor.
module tb_vscale_hasti_arbiter;

   localparam int N = 2;

   logic          hclk = 1'b0;
   logic          hresetn = 1'b0;
   logic [63:0]   m_haddr;
   logic [1:0]    m_hwrite;
   logic [5:0]    m_hsize, m_hburst;
   logic [7:0]    m_hprot;
   logic [1:0]    m_hmastlock;
   logic [3:0]    m_htrans;
   logic [63:0]   m_hwdata;
   logic [63:0]   m_hrdata;
   logic [1:0]    m_hready, m_hresp;
   logic [31:0]   s_haddr;
   logic          s_hwrite;
   logic [2:0]    s_hsize, s_hburst;
   logic [3:0]    s_hprot;
   logic          s_hmastlock;
   logic [1:0]    s_htrans;
   logic [31:0]   s_hwdata;
   logic [31:0]   s_hrdata;
   logic          s_hready, s_hresp;

   vscale_hasti_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .hclk(hclk), .hresetn(hresetn),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hprot(m_hprot), .m_hmastlock(m_hmastlock), .m_htrans(m_htrans),
      .m_hwdata(m_hwdata), .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_htrans(s_htrans),
      .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
   );

   always #5 hclk = ~hclk;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [1:0]  trans;
      logic [2:0]  burst;
   } cmd_t;

   cmd_t mq0[$], mq1[$], exp_q[$];
   cmd_t ap[2], dp[2], mon_dp;
   logic ap_act[2], dp_act[2];
   logic mon_dp_act = 1'b0;

   int n_checks = 0, n_errors = 0;
   int cnt_nr0, cnt_nr1, cnt_resp0, cnt_xfer, resp1_cnt;
   logic resp1_rdy0, resp1_rdy1;

   // Slave model state
   logic        sl_act, sl_write, sl_err, sl_err2;
   logic [31:0] sl_addr;
   int          sl_ws;

   // Values seen mid-cycle, consumed by the models at the following rising edge
   logic [1:0]  sn_m_hready, sn_m_hresp, sn_s_htrans;
   logic [63:0] sn_m_hrdata;
   logic        sn_s_hready, sn_s_hwrite;
   logic [31:0] sn_s_haddr;

   function automatic cmd_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [1:0] t, input logic [2:0] b);
      cmd_t c;
      c.addr = a; c.write = w; c.wdata = d; c.trans = t; c.burst = b;
      return c;
   endfunction

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
   endfunction

   function automatic int ws_of(input logic [31:0] a);
      return (a == 32'h300) ? 3 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_m(input int m, input cmd_t c);
      if (m == 0) mq0.push_back(c);
      else mq1.push_back(c);
   endtask

   task automatic drive_all();
      for (int i = 0; i < N; i++) begin
         m_htrans[2*i +: 2]  = ap_act[i] ? ap[i].trans : 2'b00;
         m_haddr[32*i +: 32] = ap_act[i] ? ap[i].addr : 32'h0;
         m_hwrite[i]         = ap_act[i] & ap[i].write;
         m_hburst[3*i +: 3]  = ap_act[i] ? ap[i].burst : 3'b000;
         m_hwdata[32*i +: 32] = dp_act[i] ? dp[i].wdata : 32'h0;
      end
      m_hsize     = {2{3'b010}};
      m_hprot     = {2{4'b0011}};
      m_hmastlock = 2'b00;
      s_hready = 1'b1;
      s_hresp  = 1'b0;
      s_hrdata = 32'h0;
      if (sl_act) begin
         if (sl_ws > 0) begin
            s_hready = 1'b0;
         end else if (sl_err) begin
            s_hresp  = 1'b1;
            s_hready = sl_err2;
         end
         if (!sl_write) s_hrdata = rd_of(sl_addr);
      end
   endtask

   task automatic clear_models();
      mq0.delete();
      mq1.delete();
      for (int i = 0; i < N; i++) begin
         ap_act[i] = 1'b0;
         dp_act[i] = 1'b0;
         ap[i] = '0;
         dp[i] = '0;
      end
      sl_act = 1'b0; sl_write = 1'b0; sl_err = 1'b0; sl_err2 = 1'b0;
      sl_addr = 32'h0; sl_ws = 0;
      drive_all();
   endtask

   task automatic step_models();
      for (int i = 0; i < N; i++) begin
         if (sn_m_hready[i]) begin
            if (dp_act[i] && !dp[i].write && !sn_m_hresp[i])
               chk($sformatf("m%0d_hrdata", i), sn_m_hrdata[32*i +: 32], rd_of(dp[i].addr));
            dp_act[i] = ap_act[i];
            dp[i]     = ap[i];
            ap_act[i] = 1'b0;
            if (i == 0 && mq0.size() > 0) begin ap[0] = mq0.pop_front(); ap_act[0] = 1'b1; end
            if (i == 1 && mq1.size() > 0) begin ap[1] = mq1.pop_front(); ap_act[1] = 1'b1; end
         end
      end
      if (sn_s_hready) begin
         sl_act   = sn_s_htrans[1];
         sl_addr  = sn_s_haddr;
         sl_write = sn_s_hwrite;
         sl_ws    = ws_of(sn_s_haddr);
         sl_err   = (sn_s_haddr == 32'h400);
         sl_err2  = 1'b0;
      end else if (sl_ws > 0) begin
         sl_ws--;
      end else if (sl_err) begin
         sl_err2 = 1'b1;
      end
      drive_all();
   endtask

   initial begin
      clear_models();
      forever begin
         @(posedge hclk or negedge hresetn);
         if (!hresetn) begin
            clear_models();
         end else begin
            #1;
            if (hresetn) step_models();
         end
      end
   end

   // Monitor: snapshot, scoreboard check of slave-side transfers, statistics
   always @(negedge hclk) begin
      sn_m_hready = m_hready; sn_m_hresp = m_hresp; sn_m_hrdata = m_hrdata;
      sn_s_hready = s_hready; sn_s_htrans = s_htrans;
      sn_s_haddr  = s_haddr;  sn_s_hwrite = s_hwrite;
      if (!hresetn) begin
         mon_dp_act = 1'b0;
      end else begin
         cnt_nr0   += int'(!m_hready[0]);
         cnt_nr1   += int'(!m_hready[1]);
         cnt_resp0 += int'(m_hresp[0]);
         cnt_xfer  += int'(s_htrans != 2'b00);
         if (m_hresp[1]) begin
            if (resp1_cnt == 0) resp1_rdy0 = m_hready[1];
            else if (resp1_cnt == 1) resp1_rdy1 = m_hready[1];
            resp1_cnt++;
         end
         if (s_hready) begin
            if (mon_dp_act && mon_dp.write) chk("s_hwdata", s_hwdata, mon_dp.wdata);
            mon_dp_act = 1'b0;
            if (s_htrans != 2'b00) begin
               chk("s_htrans", {30'h0, s_htrans}, 32'h2);
               chk("s_hburst", {29'h0, s_hburst}, 32'h0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_xfer actual=%h required=none", s_haddr);
               end else begin
                  mon_dp = exp_q.pop_front();
                  chk("s_haddr", s_haddr, mon_dp.addr);
                  chk("s_hwrite", {31'h0, s_hwrite}, {31'h0, mon_dp.write});
                  chk("s_hsize", {29'h0, s_hsize}, 32'h2);
                  mon_dp_act = 1'b1;
               end
            end
         end else begin
            chk("s_htrans_wait", {30'h0, s_htrans}, 32'h0);
         end
      end
   end

   function automatic bit all_idle();
      return mq0.size() == 0 && mq1.size() == 0 && !ap_act[0] && !ap_act[1] &&
             !dp_act[0] && !dp_act[1] && exp_q.size() == 0 && !mon_dp_act;
   endfunction

   task automatic clr_cnt();
      cnt_nr0 = 0; cnt_nr1 = 0; cnt_resp0 = 0; cnt_xfer = 0; resp1_cnt = 0;
      resp1_rdy0 = 1'bx; resp1_rdy1 = 1'bx;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (!all_idle() && cyc < 200) begin
         @(negedge hclk);
         cyc++;
      end
      repeat (2) @(negedge hclk);
      chk({name, "_timeout"}, (cyc >= 200) ? 32'h1 : 32'h0, 32'h0);
   endtask

   task automatic apply_reset();
      @(posedge hclk);
      #2 hresetn = 1'b0;
      exp_q.delete();
      @(posedge hclk);
      #2 hresetn = 1'b1;
      clr_cnt();
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_s_htrans"}, {30'h0, s_htrans}, 32'h0);
      chk({name, "_s_haddr"}, s_haddr, 32'h0);
      chk({name, "_s_hwdata"}, s_hwdata, 32'h0);
      chk({name, "_s_hwrite"}, {31'h0, s_hwrite}, 32'h0);
      chk({name, "_m_hready"}, {30'h0, m_hready}, 32'h3);
      chk({name, "_m_hresp"}, {30'h0, m_hresp}, 32'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      clr_cnt();
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      chk_reset_vals("rst");
      @(posedge hclk);
      #2 hresetn = 1'b1;

      // Single read from master 0: forwarded in the same cycle, zero wait
      clr_cnt();
      @(posedge hclk); #2;
      push_m(0, mk(32'h100, 1'b0, 32'h0, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h100, 1'b0, 32'h0, 2'b10, 3'b000));
      for (int c = 0; c < 10 && m_htrans[1] !== 1'b1; c++) @(negedge hclk);
      chk("fwd_s_htrans", {30'h0, s_htrans}, 32'h2);
      chk("fwd_s_haddr", s_haddr, 32'h100);
      wait_done("read0");
      chk("read0_m0_ready_low", cnt_nr0, 0);

      // Simultaneous writes: master 0 forwarded, master 1 captured for one cycle
      apply_reset();
      @(posedge hclk); #2;
      push_m(0, mk(32'h10, 1'b1, 32'h11, 2'b10, 3'b000));
      push_m(1, mk(32'h20, 1'b1, 32'h22, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h10, 1'b1, 32'h11, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h20, 1'b1, 32'h22, 2'b10, 3'b000));
      wait_done("dual_wr");
      chk("dual_wr_m1_ready_low", cnt_nr1, 1);
      chk("dual_wr_m0_ready_low", cnt_nr0, 0);

      // Master 1 INCR4 read burst against master 0 write stream
      apply_reset();
      @(posedge hclk); #2;
      for (int k = 0; k < 4; k++) begin
         push_m(0, mk(32'h80 + 32'(4*k), 1'b1, 32'hA0 + 32'(k), 2'b10, 3'b000));
         push_m(1, mk(32'h40 + 32'(4*k), 1'b0, 32'h0, (k == 0) ? 2'b10 : 2'b11, 3'b011));
      end
`ifdef VSCALE_HASTI_ARB_RR_EN
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(mk(32'h80 + 32'(4*k), 1'b1, 32'hA0 + 32'(k), 2'b10, 3'b000));
         exp_q.push_back(mk(32'h40 + 32'(4*k), 1'b0, 32'h0, 2'b10, 3'b000));
      end
`else
      for (int k = 0; k < 4; k++)
         exp_q.push_back(mk(32'h80 + 32'(4*k), 1'b1, 32'hA0 + 32'(k), 2'b10, 3'b000));
      for (int k = 0; k < 4; k++)
         exp_q.push_back(mk(32'h40 + 32'(4*k), 1'b0, 32'h0, 2'b10, 3'b000));
`endif
      wait_done("burst");

      // Three slave wait states on master 0 while master 1 sits pending
      apply_reset();
      @(posedge hclk); #2;
      push_m(0, mk(32'h300, 1'b1, 32'h33, 2'b10, 3'b000));
      push_m(1, mk(32'h20, 1'b1, 32'h44, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h300, 1'b1, 32'h33, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h20, 1'b1, 32'h44, 2'b10, 3'b000));
      wait_done("wait3");
      chk("wait3_m0_ready_low", cnt_nr0, 3);
      chk("wait3_m1_ready_low", cnt_nr1, 4);

      // Two-cycle ERROR response to master 1
      apply_reset();
      @(posedge hclk); #2;
      push_m(1, mk(32'h400, 1'b0, 32'h0, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h400, 1'b0, 32'h0, 2'b10, 3'b000));
      wait_done("err");
      chk("err_m1_resp_cycles", resp1_cnt, 2);
      chk("err_m1_ready_first", {31'h0, resp1_rdy0}, 32'h0);
      chk("err_m1_ready_second", {31'h0, resp1_rdy1}, 32'h1);
      chk("err_m0_resp_cycles", cnt_resp0, 0);

      // Reset while master 1 is pending: pending transfer must never be issued
      apply_reset();
      @(posedge hclk); #2;
      push_m(0, mk(32'h300, 1'b1, 32'h55, 2'b10, 3'b000));
      push_m(1, mk(32'h500, 1'b1, 32'h66, 2'b10, 3'b000));
      exp_q.push_back(mk(32'h300, 1'b1, 32'h55, 2'b10, 3'b000));
      repeat (3) @(posedge hclk);
      #2;
      chk("midrst_m1_pending", {31'h0, m_hready[1]}, 32'h0);
      hresetn = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(posedge hclk);
      #2 hresetn = 1'b1;
      clr_cnt();
      repeat (10) @(negedge hclk);
      chk("midrst_no_replay", cnt_xfer, 0);
      chk("midrst_exp_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
